// File: rtl/riscv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding and FSM states.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/riscv_muldiv_step.sv
// One iteration of the unsigned datapath: a shift-add multiply bit or a restoring-divide bit.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, m};
        // When ge holds the true difference is below m, so the low WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - m;
        if (is_div) begin
            hi_nxt = ge ? diff : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RISC-V M-extension unit: WIDTH-cycle shift-add multiply and restoring divide
// on operand magnitudes, with the sign applied to the final result.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    muldiv_state_t      state, state_nxt;
    muldiv_op_t         op_in, op_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, m, res;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic               accept, last, is_div_q;
    logic               a_neg, b_neg, neg_in, special;
    logic [WIDTH-1:0]   special_res, fin_res;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_in    = muldiv_op_t'(op);
    assign accept   = (state == IDLE) && req_valid && !kill;
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    always_comb begin
        a_neg       = 1'b0;
        b_neg       = 1'b0;
        neg_in      = 1'b0;
        special     = 1'b0;
        special_res = '0;
        case (op_in)
            OP_MULH:   begin a_neg = a[WIDTH-1]; b_neg = b[WIDTH-1]; neg_in = a_neg ^ b_neg; end
            OP_MULHSU: begin a_neg = a[WIDTH-1]; neg_in = a_neg; end
            OP_DIV:    begin a_neg = a[WIDTH-1]; b_neg = b[WIDTH-1]; neg_in = a_neg ^ b_neg; end
            OP_REM:    begin a_neg = a[WIDTH-1]; b_neg = b[WIDTH-1]; neg_in = a_neg; end
            default:   ;
        endcase
        // Divide-by-zero and signed overflow bypass the iteration; op[1] selects remainder.
        if (op[2] && (b == '0)) begin
            special     = 1'b1;
            special_res = op[1] ? a : '1;
        end else if ((op_in == OP_DIV || op_in == OP_REM) && (a == MIN_NEG) && (&b)) begin
            special     = 1'b1;
            special_res = op[1] ? '0 : a;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .hi     (hi),
        .lo     (lo),
        .m      (m),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    always_comb begin
        prod     = {hi_step, lo_step};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            OP_MUL:                       fin_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fin_res = cneg(lo_step, neg_q);
            default:                      fin_res = cneg(hi_step, neg_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            res   <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            cnt   <= '0;
            hi    <= '0;
            res   <= special_res;
            if (op[2]) begin
                m  <= cneg(b, b_neg);
                lo <= cneg(a, a_neg);
            end else begin
                m  <= cneg(a, a_neg);
                lo <= cneg(b, b_neg);
            end
        end else if (state == CALC && !kill) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt + CNT_W'(1);
            if (last) res <= fin_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        out        = '0;
        zero_flag  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (kill)      state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                out        = res;
                zero_flag  = (res == '0);
                if (kill || resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
